// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forwarding select codes, the scoreboard slot record and its empty value.
package pipeline_ctrl_pkg;

    localparam int HZ_REG_W = 5;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] dest;
        logic                reg_write;
        logic                mem_read;
        logic [HZ_REG_W-1:0] rs;
        logic [HZ_REG_W-1:0] rt;
        logic                uses_rt;
    } hz_slot_t;

    localparam hz_slot_t EMPTY_SLOT = '0;

    // MEM holds the newer result, so it wins over WB
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        return mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_NONE);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_match.sv
// hz_reg_match: asserts hit when a scoreboard slot will write reg_addr.
// Register $0 is hard-wired to zero and never matches.
module hz_reg_match
    import pipeline_ctrl_pkg::*;
(
    input  hz_slot_t            slot,
    input  logic [HZ_REG_W-1:0] reg_addr,
    output logic                hit
);

    logic unused_slot_bits;
    assign unused_slot_bits = ^{slot.mem_read, slot.rs, slot.rt, slot.uses_rt};

    assign hit = slot.valid & slot.reg_write & (slot.dest == reg_addr) & (reg_addr != '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline: shadow EX/MEM/WB scoreboard driving
// stalls, flushes and EX forwarding. FORWARDING_EN enables operand forwarding.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic                  mem_branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    hz_slot_t   ex_s, mem_s, wb_s, id_slot;
    logic       hazard, stall;
    logic [1:0] fwd_a_raw, fwd_b_raw;

    assign id_slot = '{valid: id_valid, dest: id_dest, reg_write: id_RegWrite,
                       mem_read: id_MemRead, rs: id_rs, rt: id_rt, uses_rt: id_uses_rt};

`ifdef FORWARDING_EN
    logic mem_hit_rs, wb_hit_rs, mem_hit_rt, wb_hit_rt;

    hz_reg_match u_mem_rs (.slot(mem_s), .reg_addr(ex_s.rs), .hit(mem_hit_rs));
    hz_reg_match u_wb_rs  (.slot(wb_s),  .reg_addr(ex_s.rs), .hit(wb_hit_rs));
    hz_reg_match u_mem_rt (.slot(mem_s), .reg_addr(ex_s.rt), .hit(mem_hit_rt));
    hz_reg_match u_wb_rt  (.slot(wb_s),  .reg_addr(ex_s.rt), .hit(wb_hit_rt));

    // Only a load still in EX is too late to forward; everything else bypasses
    assign hazard = id_valid & ex_s.valid & ex_s.mem_read & (ex_s.dest != '0) &
                    ((ex_s.dest == id_rs) | (id_uses_rt & (ex_s.dest == id_rt)));

    assign fwd_a_raw = ex_s.valid ? fwd_select(mem_hit_rs, wb_hit_rs) : FWD_NONE;
    assign fwd_b_raw = (ex_s.valid & ex_s.uses_rt) ? fwd_select(mem_hit_rt, wb_hit_rt) : FWD_NONE;
`else
    hz_slot_t   slots [3];
    logic [2:0] hit_rs, hit_rt;

    assign slots[0] = ex_s;
    assign slots[1] = mem_s;
    assign slots[2] = wb_s;

    // No bypass and no register-file write-through: wait until the producer retires
    for (genvar i = 0; i < 3; i++) begin : g_slot
        hz_reg_match u_rs (.slot(slots[i]), .reg_addr(id_rs), .hit(hit_rs[i]));
        hz_reg_match u_rt (.slot(slots[i]), .reg_addr(id_rt), .hit(hit_rt[i]));
    end

    assign hazard    = id_valid & ((|hit_rs) | (id_uses_rt & (|hit_rt)));
    assign fwd_a_raw = FWD_NONE;
    assign fwd_b_raw = FWD_NONE;
`endif

    logic unused_slot_bits;
    assign unused_slot_bits = ^{ex_s, mem_s, wb_s};

    // A taken branch squashes the stalled instruction anyway, so it takes priority
    assign stall = reset_n & hazard & ~mem_branch_taken;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        forward_a    = FWD_NONE;
        forward_b    = FWD_NONE;
        if (reset_n) begin
            forward_a = fwd_a_raw;
            forward_b = fwd_b_raw;
            if (mem_branch_taken) begin
                id_ex_bubble = 1'b1;
                if_id_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (hazard) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ex_s        <= EMPTY_SLOT;
            mem_s       <= EMPTY_SLOT;
            wb_s        <= EMPTY_SLOT;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            wb_s  <= mem_s;
            mem_s <= ex_mem_flush ? EMPTY_SLOT : ex_s;
            ex_s  <= (id_ex_bubble | ~id_valid) ? EMPTY_SLOT : id_slot;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (mem_branch_taken && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios plus a
// randomized run against an instruction-history reference model.
module tb_pipeline_hazard_controller;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt, id_dest;
    logic             id_uses_rt, id_RegWrite, id_MemRead, mem_branch_taken;
    logic             pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush;
    logic [1:0]       forward_a, forward_b;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 clock = ~clock;

    pipeline_hazard_controller #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .mem_branch_taken(mem_branch_taken), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .ex_mem_flush(ex_mem_flush), .forward_a(forward_a), .forward_b(forward_b),
        .stall_count(stall_count), .flush_count(flush_count));

    typedef struct {
        bit       v;
        bit [4:0] rs, rt, dest;
        bit       ur, rw, mr;
    } ins_t;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: instructions that entered EX 0, 1 and 2 cycles ago (EX, MEM, WB)
    ins_t hist [3];
    ins_t cur_id;
    bit   cur_br, cur_rn, m_hz;
    int   m_stall, m_flush;
    bit   exp_pc, exp_ifid, exp_bub, exp_iff, exp_emf;
    bit [1:0] exp_fa, exp_fb;

    function automatic ins_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit ur, bit [4:0] dest, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.ur = ur; i.dest = dest; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic bit writes(ins_t s, bit [4:0] r);
        return s.v && s.rw && s.dest == r && r != 0;
    endfunction

    function automatic bit [1:0] newest_src(bit [4:0] r);
        if (writes(hist[1], r)) return 2'b10;
        if (writes(hist[2], r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        m_hz = 0; exp_fa = 0; exp_fb = 0;
`ifdef FORWARDING_EN
        m_hz = cur_id.v && hist[0].v && hist[0].mr && hist[0].dest != 0 &&
               (hist[0].dest == cur_id.rs || (cur_id.ur && hist[0].dest == cur_id.rt));
        if (hist[0].v) begin
            exp_fa = newest_src(hist[0].rs);
            if (hist[0].ur) exp_fb = newest_src(hist[0].rt);
        end
`else
        for (int k = 0; k < 3; k++)
            if (writes(hist[k], cur_id.rs) || (cur_id.ur && writes(hist[k], cur_id.rt)))
                m_hz = cur_id.v;
`endif
        {exp_pc, exp_ifid, exp_bub, exp_iff, exp_emf} = 5'b11000;
        if (!cur_rn) begin
            exp_fa = 0; exp_fb = 0;
        end else if (cur_br) begin
            {exp_pc, exp_ifid, exp_bub, exp_iff, exp_emf} = 5'b11111;
        end else if (m_hz) begin
            {exp_pc, exp_ifid, exp_bub} = 3'b001;
        end
    endtask

    task automatic model_tick();
        if (!cur_rn) begin
            for (int k = 0; k < 3; k++) hist[k] = mk(0, 0, 0, 0, 0, 0, 0);
            m_stall = 0; m_flush = 0;
        end else begin
            if (m_hz && !cur_br && m_stall < CNT_MAX) m_stall++;
            if (cur_br && m_flush < CNT_MAX) m_flush++;
            hist[2] = hist[1];
            hist[1] = exp_emf ? mk(0, 0, 0, 0, 0, 0, 0) : hist[0];
            hist[0] = (exp_bub || !cur_id.v) ? mk(0, 0, 0, 0, 0, 0, 0) : cur_id;
        end
    endtask

    // Apply one cycle of inputs and settle at the falling edge
    task automatic drive(input ins_t id, input bit br, input bit rn);
        reset_n = rn; id_valid = id.v; id_rs = id.rs; id_rt = id.rt; id_uses_rt = id.ur;
        id_dest = id.dest; id_RegWrite = id.rw; id_MemRead = id.mr; mem_branch_taken = br;
        cur_id = id; cur_br = br; cur_rn = rn;
        model_eval();
        @(negedge clock);
    endtask

    task automatic tick();
        @(posedge clock);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0), 0, 0);
        tick();
    endtask

    ins_t nop, add17, sub18, lw8, add17b, add0, add_z;

    task automatic test_reset();
        drive(mk(1, 3, 3, 1, 3, 1, 1), 1, 0);
        n_checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush, forward_a, forward_b} !== 9'b110000000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=110000000",
                     {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush, forward_a, forward_b});
        end
        tick();
        drive(nop, 0, 1);
        n_checks++;
        if (stall_count !== 0 || flush_count !== 0) begin
            n_fail++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        tick();
    endtask

    task automatic test_dependent_alu();
        int stalls = 0;
        do_reset();
        drive(add17, 0, 1); tick();
        for (int c = 0; c < 6; c++) begin
            drive(sub18, 0, 1);
            if (if_id_write) break;
            stalls++;
            n_checks++;
            if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
                n_fail++;
                $display("FAIL dep_alu_stall_fwd got=%b/%b want=00/00", forward_a, forward_b);
            end
            tick();
        end
        tick();
        drive(nop, 0, 1);
`ifdef FORWARDING_EN
        n_checks++;
        if (stalls != 0 || forward_a !== 2'b10 || forward_b !== 2'b00) begin
            n_fail++;
            $display("FAIL dep_alu_fwd got stalls=%0d fa=%b fb=%b want 0/10/00", stalls, forward_a, forward_b);
        end
        n_checks++;
        if (stall_count !== 0) begin
            n_fail++;
            $display("FAIL dep_alu_count got=%0d want=0", stall_count);
        end
`else
        n_checks++;
        if (stalls != 3 || forward_a !== 2'b00 || forward_b !== 2'b00) begin
            n_fail++;
            $display("FAIL dep_alu_nofwd got stalls=%0d fa=%b fb=%b want 3/00/00", stalls, forward_a, forward_b);
        end
        n_checks++;
        if (stall_count !== 3) begin
            n_fail++;
            $display("FAIL dep_alu_count got=%0d want=3", stall_count);
        end
`endif
        tick();
    endtask

    task automatic test_load_use();
        int stalls = 0;
        do_reset();
        drive(lw8, 0, 1); tick();
        for (int c = 0; c < 6; c++) begin
            drive(add17b, 0, 1);
            if (if_id_write) break;
            stalls++;
            n_checks++;
            if (pc_write !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_flush !== 1'b0) begin
                n_fail++;
                $display("FAIL load_use_stall got pc=%b bub=%b iff=%b want 0/1/0", pc_write, id_ex_bubble, if_id_flush);
            end
            tick();
        end
        tick();
        drive(nop, 0, 1);
`ifdef FORWARDING_EN
        n_checks++;
        if (stalls != 1 || forward_a !== 2'b01 || stall_count !== 1) begin
            n_fail++;
            $display("FAIL load_use got stalls=%0d fa=%b cnt=%0d want 1/01/1", stalls, forward_a, stall_count);
        end
`else
        n_checks++;
        if (stalls != 3 || forward_a !== 2'b00 || stall_count !== 3) begin
            n_fail++;
            $display("FAIL load_use got stalls=%0d fa=%b cnt=%0d want 3/00/3", stalls, forward_a, stall_count);
        end
`endif
        tick();
    endtask

    task automatic test_zero_dest();
        do_reset();
        drive(add0, 0, 1); tick();
        drive(add_z, 0, 1);
        n_checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_dest_stall got pc=%b ifid=%b bub=%b want 1/1/0", pc_write, if_id_write, id_ex_bubble);
        end
        tick();
        drive(nop, 0, 1);
        n_checks++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_dest_fwd got=%b/%b want=00/00", forward_a, forward_b);
        end
        tick();
    endtask

    task automatic test_branch_vs_stall();
        do_reset();
        drive(lw8, 0, 1); tick();
        drive(add17b, 1, 1);
        n_checks++;
        if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush} !== 5'b11111) begin
            n_fail++;
            $display("FAIL branch_priority got=%b want=11111",
                     {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush});
        end
        tick();
        drive(nop, 0, 1);
        n_checks++;
        if (stall_count !== 0 || flush_count !== 1) begin
            n_fail++;
            $display("FAIL branch_counts got=%0d/%0d want=0/1", stall_count, flush_count);
        end
        n_checks++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
            n_fail++;
            $display("FAIL branch_flushed_fwd got=%b/%b want=00/00", forward_a, forward_b);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(add17, 0, 1); tick();
        drive(add17, 0, 1); tick();
        drive(lw8, 0, 1); tick();
        drive(add17b, 0, 1);
        n_checks++;
        if (pc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stall_setup got pc=%b want=0", pc_write);
        end
        drive(add17b, 0, 0);
        n_checks++;
        if (pc_write !== 1'b1 || if_id_write !== 1'b1 || id_ex_bubble !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stall_during_reset got pc=%b ifid=%b bub=%b want 1/1/0", pc_write, if_id_write, id_ex_bubble);
        end
        tick();
        drive(add17b, 0, 1);
        n_checks++;
        if (pc_write !== 1'b1 || stall_count !== 0 || flush_count !== 0 || forward_a !== 0 || forward_b !== 0) begin
            n_fail++;
            $display("FAIL mid_stall_after_reset got pc=%b cnt=%0d/%0d fwd=%b/%b want 1 0/0 00/00",
                     pc_write, stall_count, flush_count, forward_a, forward_b);
        end
        tick();
    endtask

    task automatic test_random();
        ins_t id;
        bit br, rn, held, flushed;
        held = 0; flushed = 0;
        id = nop;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rn = ($urandom_range(0, 99) != 0);
            br = ($urandom_range(0, 9) == 0);
            if (flushed) id = nop;
            else if (!held) begin
                bit mr = ($urandom_range(0, 2) == 0);
                id = mk($urandom_range(0, 6) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        1'($urandom), 5'($urandom_range(0, 3)), mr | 1'($urandom), mr);
            end
            drive(id, br, rn);
            n_checks++;
            if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush, forward_a, forward_b} !==
                {exp_pc, exp_ifid, exp_bub, exp_iff, exp_emf, exp_fa, exp_fb}) begin
                n_fail++;
                $display("FAIL random_outputs cyc=%0d got=%b want=%b", c,
                         {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_flush, forward_a, forward_b},
                         {exp_pc, exp_ifid, exp_bub, exp_iff, exp_emf, exp_fa, exp_fb});
            end
            held    = rn && !exp_ifid;
            flushed = rn && exp_iff;
            tick();
            n_checks++;
            if (stall_count !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush)) begin
                n_fail++;
                $display("FAIL random_counters cyc=%0d got=%0d/%0d want=%0d/%0d", c,
                         stall_count, flush_count, m_stall, m_flush);
            end
        end
    endtask

    initial begin
        nop    = mk(0, 0, 0, 0, 0, 0, 0);
        add17  = mk(1, 8, 9, 1, 17, 1, 0);
        sub18  = mk(1, 17, 9, 1, 18, 1, 0);
        lw8    = mk(1, 9, 0, 0, 8, 1, 1);
        add17b = mk(1, 8, 9, 1, 17, 1, 0);
        add0   = mk(1, 8, 9, 1, 0, 1, 0);
        add_z  = mk(1, 0, 0, 1, 17, 1, 0);
        for (int k = 0; k < 3; k++) hist[k] = nop;
        m_stall = 0; m_flush = 0;
        reset_n = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_dest = 0; id_RegWrite = 0; id_MemRead = 0; mem_branch_taken = 0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_dependent_alu();
        test_load_use();
        test_zero_dest();
        test_branch_vs_stall();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central hazard sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow scoreboard of the instructions in EX, MEM and WB.
- From that scoreboard it drives:
  - PC and IF/ID write-enables;
  - ID/EX bubble insertion;
  - branch flushes;
  - EX-stage operand forwarding selects.
- Sits beside the ID stage and the ID_EX_Register; it replaces ad-hoc stall logic in the top level.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_ADDR_W  ID source register 1.
- id_rt  in  REG_ADDR_W  ID source register 2.
- id_uses_rt  in  1  instruction reads rt as a source (R-type, sw, beq).
- id_dest  in  REG_ADDR_W  destination after RegDst selection.
- id_RegWrite  in  1  ID control: writes the register file.
- id_MemRead  in  1  ID control: load.
- mem_branch_taken  in  1  branch resolved taken in MEM this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_bubble  out  1  zero control fields into ID/EX.
- if_id_flush  out  1  clear IF/ID.
- ex_mem_flush  out  1  zero control fields into EX/MEM.
- forward_a  out  2  EX ALU operand A select.
- forward_b  out  2  EX ALU operand B select.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Scoreboard slots: ex_s, mem_s, wb_s.
  - Each slot holds {valid, dest, RegWrite, MemRead, rs, rt, uses_rt}.
  - A slot "writes R" when valid & RegWrite & dest==R & R!=0.
- Slot advance every posedge:
  - wb_s <= mem_s.
  - mem_s <= ex_mem_flush ? empty : ex_s.
  - ex_s <= (id_ex_bubble | !id_valid) ? empty : ID inputs.
- Load-use stall (combinational): ex_s valid & MemRead & dest!=0 & (dest==id_rs | (id_uses_rt & dest==id_rt)) & id_valid.
  - Result: pc_write=0, if_id_write=0, id_ex_bubble=1, for exactly 1 cycle.
- Taken branch (mem_branch_taken=1):
  - if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, pc_write=1 (branch target loads).
  - Overrides any stall in the same cycle; that cycle is not counted in stall_count.
- Forwarding (combinational from registered slots; output 0 when ex_s is empty):
  - forward_a=2'b10 if mem_s writes ex_s.rs.
  - Else forward_a=2'b01 if wb_s writes ex_s.rs.
  - Else forward_a=2'b00.
  - forward_b: same rule using ex_s.rt, and only when ex_s.uses_rt.
  - MEM has priority over WB, so the newest value wins.
- Counters:
  - stall_count +1 per stall cycle; flush_count +1 per taken-branch cycle.
  - Both saturate at all-ones; no wrap.
- Reset (reset_n=0 at posedge):
  - All slots empty; counters 0.
  - Outputs during and after reset: pc_write=1, if_id_write=1; all others 0.
  - Reset mid-stall cancels the stall on the next cycle.
- Register $0 never causes a stall or a forward.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: behaviour exactly as above.
- Undefined:
  - forward_a and forward_b are tied to 2'b00.
  - Stall is asserted while any of ex_s, mem_s or wb_s writes id_rs (or id_rt when id_uses_rt); the register file has no write-through.
  - A dependent instruction therefore stalls up to 3 cycles.
  - Taken-branch priority is unchanged.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - typedef hz_slot_t (slot fields).
  - EMPTY_SLOT constant.
- One natural sub-module: hz_reg_match.
  - Combinational "slot writes R" comparator.
  - Instantiated for each slot/operand pair.

Test Plan:
- Dependent ALU ops: add $17,$8,$9 then sub $18,$17,$9 -> no stall; the cycle sub is in EX, forward_a=2'b10, forward_b=2'b00.
- Load-use: lw $8,0($9) then add $17,$8,$9 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; then add in EX gives forward_a=2'b01; stall_count=1.
- $0 destination: add $0,$8,$9 then add $17,$0,$0 -> no stall; forward_a=forward_b=2'b00.
- Branch vs stall: mem_branch_taken=1 in the same cycle as a load-use hazard -> if_id_flush=1, ex_mem_flush=1, pc_write=1; stall_count unchanged; flush_count +1.
- FORWARDING_EN undefined: add $17,$8,$9 then sub $18,$17,$9 -> 3 stall cycles; stall_count=3; forwards stay 2'b00.
- Reset mid-stall: reset_n=0 during a load-use stall -> next cycle pc_write=1, counters 0, slots empty; no spurious forward.
